// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage core
// Drives PC and stage-register en/clear pairs; counts stall cycles and branch flushes.
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_r_datamem,
  input  logic             ex_regfile_w_en,
  input  logic [4:0]       ex_regfile_req_w,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             pc_en,
  output logic             en_ps1,
  output logic             en_ps2,
  output logic             en_ps3,
  output logic             en_ps4,
  output logic             clear_ps1,
  output logic             clear_ps2,
  output logic             clear_ps3,
  output logic             clear_ps4,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(MEM_LAT - 1);
  localparam bit MULTI = (MEM_LAT > 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          flush_evt;
  logic          load_use;

  assign load_use = ex_r_datamem && ex_regfile_w_en && (ex_regfile_req_w != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_regfile_req_w)) ||
                     (id_use_rt && (id_rt == ex_regfile_req_w)));

  assign halted = (state == HALT);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    flush_evt = 1'b0;
    pc_en     = 1'b1;
    en_ps1    = 1'b1;
    en_ps2    = 1'b1;
    en_ps3    = 1'b1;
    en_ps4    = 1'b1;
    clear_ps1 = 1'b1;
    clear_ps2 = 1'b1;
    clear_ps3 = 1'b1;
    clear_ps4 = 1'b1;
    if (state == HALT) begin
      wait_nxt = '0;
      pc_en    = 1'b0;
      en_ps1   = 1'b0;
      en_ps2   = 1'b0;
      en_ps3   = 1'b0;
      if (resume) begin
        // Bubble replaces the syscall in WB; MEM moves on the following cycle.
        clear_ps4 = 1'b0;
        state_nxt = RUN;
      end else begin
        en_ps4 = 1'b0;
      end
    end else if (wb_halt) begin
      pc_en     = 1'b0;
      en_ps1    = 1'b0;
      en_ps2    = 1'b0;
      en_ps3    = 1'b0;
      en_ps4    = 1'b0;
      wait_nxt  = '0;
      state_nxt = HALT;
    end else if (MULTI && mem_access && (wait_cnt < LAST_WAIT)) begin
      pc_en     = 1'b0;
      en_ps1    = 1'b0;
      en_ps2    = 1'b0;
      en_ps3    = 1'b0;
      clear_ps4 = 1'b0;
      wait_nxt  = wait_cnt + WW'(1);
      state_nxt = MEMWAIT;
    end else begin
      wait_nxt  = '0;
      state_nxt = RUN;
      if (ex_branch_taken) begin
        clear_ps1 = 1'b0;
        clear_ps2 = 1'b0;
        flush_evt = 1'b1;
      end else if (load_use) begin
        pc_en     = 1'b0;
        en_ps1    = 1'b0;
        clear_ps2 = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
// Two instances (MEM_LAT=1/CNT_W=32 and MEM_LAT=3/CNT_W=4) share one stimulus stream.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       ld;
    logic       wen;
    logic [4:0] dst;
    logic       br;
    logic       mem;
    logic       halt;
    logic       res;
  } stim_t;

  // en/clr bit 3 = PS4 ... bit 0 = PS1
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] clr;
    logic       halted;
  } outs_t;

  typedef struct {
    stim_t s;
    outs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_regfile_req_w = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_r_datamem = 0, ex_regfile_w_en = 0;
  logic ex_branch_taken = 0, mem_access = 0, wb_halt = 0, resume = 0;

  logic pc_a, e1_a, e2_a, e3_a, e4_a, c1_a, c2_a, c3_a, c4_a, h_a;
  logic pc_b, e1_b, e2_b, e3_b, e4_b, c1_b, c2_b, c3_b, c4_b, h_b;
  logic [31:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  outs_t       act [2];
  logic [63:0] act_stall [2];
  logic [63:0] act_flush [2];

  int total = 0;
  int bad = 0;

  bit      m_hlt [2];
  int      m_wait [2];
  longint  m_stall [2];
  longint  m_flush [2];
  int      lat [2] = '{1, 3};
  longint  cmax [2] = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_r_datamem(ex_r_datamem), .ex_regfile_w_en(ex_regfile_w_en),
    .ex_regfile_req_w(ex_regfile_req_w), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .wb_halt(wb_halt), .resume(resume), .pc_en(pc_a),
    .en_ps1(e1_a), .en_ps2(e2_a), .en_ps3(e3_a), .en_ps4(e4_a),
    .clear_ps1(c1_a), .clear_ps2(c2_a), .clear_ps3(c3_a), .clear_ps4(c4_a),
    .halted(h_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_r_datamem(ex_r_datamem), .ex_regfile_w_en(ex_regfile_w_en),
    .ex_regfile_req_w(ex_regfile_req_w), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .wb_halt(wb_halt), .resume(resume), .pc_en(pc_b),
    .en_ps1(e1_b), .en_ps2(e2_b), .en_ps3(e3_b), .en_ps4(e4_b),
    .clear_ps1(c1_b), .clear_ps2(c2_b), .clear_ps3(c3_b), .clear_ps4(c4_b),
    .halted(h_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  assign act[0] = {pc_a, e4_a, e3_a, e2_a, e1_a, c4_a, c3_a, c2_a, c1_a, h_a};
  assign act[1] = {pc_b, e4_b, e3_b, e2_b, e1_b, c4_b, c3_b, c2_b, c1_b, h_b};
  assign act_stall[0] = {32'd0, stall_a};
  assign act_flush[0] = {32'd0, flush_a};
  assign act_stall[1] = {60'd0, stall_b};
  assign act_flush[1] = {60'd0, flush_b};

  function automatic stim_t mk(input int rs, input int rt, input bit urs, input bit urt,
                               input bit ld, input bit wen, input int dst, input bit br,
                               input bit mem, input bit halt, input bit res);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.use_rs = urs; s.use_rt = urt;
    s.ld = ld; s.wen = wen; s.dst = 5'(dst); s.br = br;
    s.mem = mem; s.halt = halt; s.res = res;
    return s;
  endfunction

  // Expected control word from the priority rules: halt > memory wait > branch > load-use.
  function automatic outs_t ref_out(input stim_t s, input int l, input bit hlt, input int waited,
                                    output bit flush, output int nwait, output bit nhlt);
    outs_t o;
    bit hazard;
    hazard = s.ld && s.wen && (s.dst != 0) &&
             ((s.use_rs && s.rs == s.dst) || (s.use_rt && s.rt == s.dst));
    o = '{pc_en: 1'b1, en: 4'hF, clr: 4'hF, halted: hlt};
    flush = 0; nwait = 0; nhlt = hlt;
    if (hlt) begin
      o.pc_en = 0;
      if (s.res) begin o.en = 4'b1000; o.clr = 4'b0111; nhlt = 0; end
      else o.en = 4'b0000;
    end else if (s.halt) begin
      o.pc_en = 0; o.en = 4'b0000; nhlt = 1;
    end else if (s.mem && waited < l - 1) begin
      o.pc_en = 0; o.en = 4'b1000; o.clr = 4'b0111; nwait = waited + 1;
    end else if (s.br) begin
      o.clr = 4'b1100; flush = 1;
    end else if (hazard) begin
      o.pc_en = 0; o.en = 4'b1110; o.clr = 4'b1101;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hlt[d] = 0; m_wait[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
    end
  endtask

  // One clock: drive, check both instances against the model at negedge, advance model at posedge.
  task automatic step(input stim_t s, input int td, input outs_t te, input string nm);
    outs_t o;
    bit fl [2];
    bit nh [2];
    int nw [2];
    id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    ex_r_datamem = s.ld; ex_regfile_w_en = s.wen; ex_regfile_req_w = s.dst;
    ex_branch_taken = s.br; mem_access = s.mem; wb_halt = s.halt; resume = s.res;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = ref_out(s, lat[d], m_hlt[d], m_wait[d], fl[d], nw[d], nh[d]);
      chk($sformatf("%s_d%0d_ctrl", nm, d), 64'(act[d]), 64'(o));
      chk($sformatf("%s_d%0d_stall", nm, d), act_stall[d], 64'(m_stall[d]));
      chk($sformatf("%s_d%0d_flush", nm, d), act_flush[d], 64'(m_flush[d]));
      if (!o.pc_en && m_stall[d] < cmax[d]) m_stall[d]++;
      if (fl[d] && m_flush[d] < cmax[d]) m_flush[d]++;
    end
    if (td >= 0) chk({nm, "_const"}, 64'(act[td]), 64'(te));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_hlt[d] = nh[d]; m_wait[d] = nw[d];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  localparam outs_t O_IDLE  = {1'b1, 4'hF, 4'hF, 1'b0};
  localparam outs_t O_LU    = {1'b0, 4'b1110, 4'b1101, 1'b0};
  localparam outs_t O_BR    = {1'b1, 4'hF, 4'b1100, 1'b0};
  localparam outs_t O_MEMW  = {1'b0, 4'b1000, 4'b0111, 1'b0};
  localparam outs_t O_HENT  = {1'b0, 4'b0000, 4'hF, 1'b0};
  localparam outs_t O_HOLD  = {1'b0, 4'b0000, 4'hF, 1'b1};
  localparam outs_t O_RES   = {1'b0, 4'b1000, 4'b0111, 1'b1};

  vec_t  tbl [10];
  stim_t idle, lu8, s;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu8  = mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0);
    tbl[0] = '{s: idle, e: O_IDLE};
    tbl[1] = '{s: lu8, e: O_LU};
    tbl[2] = '{s: mk(3, 8, 0, 1, 1, 1, 8, 0, 0, 0, 0), e: O_LU};
    tbl[3] = '{s: mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0), e: O_IDLE};
    tbl[4] = '{s: mk(8, 0, 1, 0, 1, 1, 8, 1, 0, 0, 0), e: O_BR};
    tbl[5] = '{s: mk(8, 8, 0, 0, 1, 1, 8, 0, 0, 0, 0), e: O_IDLE};
    tbl[6] = '{s: mk(8, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0), e: O_IDLE};
    tbl[7] = '{s: mk(8, 0, 1, 0, 1, 0, 8, 0, 0, 0, 0), e: O_IDLE};
    tbl[8] = '{s: mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), e: O_IDLE};
    tbl[9] = '{s: mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), e: O_IDLE};

    model_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(idle, 0, O_IDLE, "idle");
    chk("reset_stall", 64'(stall_a), 64'd0);
    chk("reset_flush", 64'(flush_a), 64'd0);

    for (int i = 0; i < 10; i++) step(tbl[i].s, 0, tbl[i].e, $sformatf("tbl%0d", i));

    // single load-use bubble, then $0 destination never stalls
    do_reset();
    step(lu8, 0, O_LU, "lu_r8");
    step(idle, 0, O_IDLE, "lu_after");
    chk("lu_stall", 64'(stall_a), 64'd1);
    step(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), 0, O_IDLE, "lu_r0");
    chk("lu_r0_stall", 64'(stall_a), 64'd1);

    // branch wins over load-use
    do_reset();
    step(mk(8, 0, 1, 0, 1, 1, 8, 1, 0, 0, 0), 0, O_BR, "br_lu");
    chk("br_flush", 64'(flush_a), 64'd1);
    chk("br_stall", 64'(stall_a), 64'd0);

    // MEM_LAT=3 freeze; branch masked until release
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, O_MEMW, "mw1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 1, O_MEMW, "mw2");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 1, O_BR, "mw3");
    step(idle, 1, O_IDLE, "mw4");
    chk("mw_stall", 64'(stall_b), 64'd2);
    chk("mw_flush", 64'(flush_b), 64'd1);

    // halt, hold, resume
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, O_HENT, "h_enter");
    for (int i = 0; i < 5; i++) step(idle, 0, O_HOLD, "h_hold");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, O_RES, "h_resume");
    chk("h_stall", 64'(stall_a), 64'd7);
    step(idle, 0, O_IDLE, "h_run");

    // saturation on the 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) step(lu8, 1, O_LU, "sat");
    chk("sat_b", 64'(stall_b), 64'd15);
    chk("sat_a", 64'(stall_a), 64'd20);

    // asynchronous reset while halted
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), -1, O_IDLE, "ar_enter");
    step(idle, 0, O_HOLD, "ar_hold");
    rst_n = 0;
    #1;
    chk("ar_halted_a", 64'(h_a), 64'd0);
    chk("ar_halted_b", 64'(h_b), 64'd0);
    chk("ar_stall_a", 64'(stall_a), 64'd0);
    chk("ar_stall_b", 64'(stall_b), 64'd0);
    chk("ar_flush_b", 64'(flush_b), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      s = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
      step(s, -1, O_IDLE, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
